// File: rtl/mem_read_port.sv
// Single-outstanding read engine: accepts an address, strobes a synchronous RAM,
// waits the fixed RAM latency, then holds the returned word until the consumer takes it.
module mem_read_port #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy
);

    if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_latency
        $error("mem_read_port: READ_LATENCY must be in 1..15");
    end

    localparam logic [3:0] LAT = 4'(READ_LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] count;
    logic       accept;
    logic       capture;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (count == 4'd1) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // counter is loaded on acceptance but only counts down in WAIT, so the
    // capture edge lands READ_LATENCY+1 edges after the accepting edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            count     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (accept) begin
                mem_addr <= req_addr;
                mem_rd   <= 1'b1;
                count    <= LAT;
            end
            if (state == ISSUE) begin
                mem_rd <= 1'b0;
            end
            if (state == WAIT) begin
                count <= count - 4'd1;
            end
            if (capture) begin
                rsp_data  <= mem_data_in;
                rsp_valid <= 1'b1;
            end
            if (state == HOLD && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_read_port.sv
// Bench for mem_read_port: a READ_LATENCY=1 instance driven from a per-cycle
// vector table and a READ_LATENCY=3 instance exercised by hand-written sequences.
module tb_mem_read_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance with latency 1
    logic       reset1 = 1'b1;
    logic       req_valid1 = 1'b0, rsp_ready1 = 1'b0;
    logic [7:0] req_addr1 = '0;
    logic       req_ready1, mem_rd1, rsp_valid1, busy1;
    logic [7:0] mem_addr1, mem_data_in1, rsp_data1;

    // instance with latency 3
    logic       reset3 = 1'b1;
    logic       req_valid3 = 1'b0, rsp_ready3 = 1'b0;
    logic [7:0] req_addr3 = '0;
    logic       req_ready3, mem_rd3, rsp_valid3, busy3;
    logic [7:0] mem_addr3, mem_data_in3, rsp_data3;

    mem_read_port #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset1),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
        .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_data_in(mem_data_in1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
        .busy(busy1)
    );

    mem_read_port #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset3),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr3),
        .mem_addr(mem_addr3), .mem_rd(mem_rd3), .mem_data_in(mem_data_in3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
        .busy(busy3)
    );

    // RAM models: data is only meaningful for the cycles tied to a sampled mem_rd
    logic [7:0] ram1 [256];
    logic [7:0] ram3 [256];
    logic [7:0] pipe1;
    logic [7:0] pipe3 [3];

    always @(posedge clk) begin
        pipe1    <= mem_rd1 ? ram1[mem_addr1] : 8'hEE;
        pipe3[0] <= mem_rd3 ? ram3[mem_addr3] : 8'hEE;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mem_data_in1 = pipe1;
    assign mem_data_in3 = pipe3[2];

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rv;
        logic [7:0] addr;
        logic       rr;
        logic       e_rdy;
        logic       e_rd;
        logic [7:0] e_addr;
        logic       e_rv;
        logic [7:0] e_data;
        logic       e_busy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rv, input logic [7:0] addr, input logic rr,
                       input logic e_rdy, input logic e_rd, input logic [7:0] e_addr,
                       input logic e_rv, input logic [7:0] e_data, input logic e_busy);
        vec_t v;
        v.rv = rv; v.addr = addr; v.rr = rr;
        v.e_rdy = e_rdy; v.e_rd = e_rd; v.e_addr = e_addr;
        v.e_rv = e_rv; v.e_data = e_data; v.e_busy = e_busy;
        vq.push_back(v);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram1[i] = 8'(i) ^ 8'h5C;
            ram3[i] = 8'(i) ^ 8'h91;
        end
        ram1[8'h80] = 8'hA5;
        ram1[8'hFF] = 8'h5A;
        ram1[8'h00] = 8'hC3;
        ram1[8'h01] = 8'h77;
        ram3[8'h10] = 8'h3C;

        // inputs: rv addr rr | expected after edge: rdy rd addr rv data busy
        // single read of 0x80
        add(1, 8'h80, 0,  0, 1, 8'h80, 0, 8'h00, 1);
        add(0, 8'h00, 0,  0, 0, 8'h80, 0, 8'h00, 1);
        add(0, 8'h00, 0,  0, 0, 8'h80, 1, 8'hA5, 1);
        // backpressure with a pending request for 0x01
        for (int i = 0; i < 5; i++)
            add(1, 8'h01, 0,  0, 0, 8'h80, 1, 8'hA5, 1);
        add(0, 8'h01, 1,  1, 0, 8'h80, 0, 8'hA5, 0);
        // read 0x01, then overlap completion with a new request for 0xFF
        add(1, 8'h01, 0,  0, 1, 8'h01, 0, 8'hA5, 1);
        add(0, 8'h00, 0,  0, 0, 8'h01, 0, 8'hA5, 1);
        add(0, 8'h00, 0,  0, 0, 8'h01, 1, 8'h77, 1);
        add(1, 8'hFF, 1,  1, 0, 8'h01, 0, 8'h77, 0);
        add(1, 8'hFF, 1,  0, 1, 8'hFF, 0, 8'h77, 1);
        add(0, 8'h00, 1,  0, 0, 8'hFF, 0, 8'h77, 1);
        add(0, 8'h00, 1,  0, 0, 8'hFF, 1, 8'h5A, 1);
        add(0, 8'h00, 1,  1, 0, 8'hFF, 0, 8'h5A, 0);
        // stream 0x00, 0xFF, 0x00 with rsp_ready tied high
        add(1, 8'h00, 1,  0, 1, 8'h00, 0, 8'h5A, 1);
        add(1, 8'hFF, 1,  0, 0, 8'h00, 0, 8'h5A, 1);
        add(1, 8'hFF, 1,  0, 0, 8'h00, 1, 8'hC3, 1);
        add(1, 8'hFF, 1,  1, 0, 8'h00, 0, 8'hC3, 0);
        add(1, 8'hFF, 1,  0, 1, 8'hFF, 0, 8'hC3, 1);
        add(1, 8'h00, 1,  0, 0, 8'hFF, 0, 8'hC3, 1);
        add(1, 8'h00, 1,  0, 0, 8'hFF, 1, 8'h5A, 1);
        add(1, 8'h00, 1,  1, 0, 8'hFF, 0, 8'h5A, 0);
        add(1, 8'h00, 1,  0, 1, 8'h00, 0, 8'h5A, 1);
        add(0, 8'h00, 1,  0, 0, 8'h00, 0, 8'h5A, 1);
        add(0, 8'h00, 1,  0, 0, 8'h00, 1, 8'hC3, 1);
        add(0, 8'h00, 1,  1, 0, 8'h00, 0, 8'hC3, 0);

        // asynchronous reset, checked before any clock edge
        #2;
        reset1 = 1'b0;
        reset3 = 1'b0;
        #1;
        chk("reset.req_ready", 32'(req_ready1), 32'd1);
        chk("reset.mem_rd",    32'(mem_rd1),    32'd0);
        chk("reset.mem_addr",  32'(mem_addr1),  32'd0);
        chk("reset.rsp_valid", 32'(rsp_valid1), 32'd0);
        chk("reset.rsp_data",  32'(rsp_data1),  32'd0);
        chk("reset.busy",      32'(busy1),      32'd0);
        tick();
        tick();
        reset1 = 1'b1;
        reset3 = 1'b1;

        foreach (vq[i]) begin
            req_valid1 = vq[i].rv;
            req_addr1  = vq[i].addr;
            rsp_ready1 = vq[i].rr;
            tick();
            chk($sformatf("v%0d.req_ready", i), 32'(req_ready1), 32'(vq[i].e_rdy));
            chk($sformatf("v%0d.mem_rd", i),    32'(mem_rd1),    32'(vq[i].e_rd));
            chk($sformatf("v%0d.mem_addr", i),  32'(mem_addr1),  32'(vq[i].e_addr));
            chk($sformatf("v%0d.rsp_valid", i), 32'(rsp_valid1), 32'(vq[i].e_rv));
            chk($sformatf("v%0d.rsp_data", i),  32'(rsp_data1),  32'(vq[i].e_data));
            chk($sformatf("v%0d.busy", i),      32'(busy1),      32'(vq[i].e_busy));
        end
        req_valid1 = 1'b0;

        // latency 3: read 0x10, response rises after the fourth edge past acceptance
        rsp_ready3 = 1'b1;
        req_valid3 = 1'b1;
        req_addr3  = 8'h10;
        tick();
        req_valid3 = 1'b0;
        chk("l3.e0.mem_rd",   32'(mem_rd3),   32'd1);
        chk("l3.e0.mem_addr", 32'(mem_addr3), 32'h10);
        chk("l3.e0.busy",     32'(busy3),     32'd1);
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("l3.e%0d.mem_rd", e),    32'(mem_rd3),    32'd0);
            chk($sformatf("l3.e%0d.rsp_valid", e), 32'(rsp_valid3), 32'd0);
            chk($sformatf("l3.e%0d.busy", e),      32'(busy3),      32'd1);
        end
        tick();
        chk("l3.e4.rsp_valid", 32'(rsp_valid3), 32'd1);
        chk("l3.e4.rsp_data",  32'(rsp_data3),  32'h3C);
        chk("l3.e4.busy",      32'(busy3),      32'd1);
        tick();
        chk("l3.e5.rsp_valid", 32'(rsp_valid3), 32'd0);
        chk("l3.e5.busy",      32'(busy3),      32'd0);
        chk("l3.e5.req_ready", 32'(req_ready3), 32'd1);

        // reset two edges after acceptance, while the read is in flight
        req_valid3 = 1'b1;
        req_addr3  = 8'h10;
        tick();
        req_valid3 = 1'b0;
        tick();
        tick();
        chk("rst_wait.busy_before", 32'(busy3), 32'd1);
        reset3 = 1'b0;
        #1;
        chk("rst_wait.mem_rd",    32'(mem_rd3),    32'd0);
        chk("rst_wait.rsp_valid", 32'(rsp_valid3), 32'd0);
        chk("rst_wait.rsp_data",  32'(rsp_data3),  32'd0);
        chk("rst_wait.mem_addr",  32'(mem_addr3),  32'd0);
        chk("rst_wait.req_ready", 32'(req_ready3), 32'd1);
        tick();
        reset3 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("rst_wait.c%0d.rsp_valid", c), 32'(rsp_valid3), 32'd0);
            chk($sformatf("rst_wait.c%0d.mem_rd", c),    32'(mem_rd3),    32'd0);
            chk($sformatf("rst_wait.c%0d.req_ready", c), 32'(req_ready3), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
